tea_decrypt_iter: RTL and testbench
===================================

Name: tea_decrypt_iter

Overview:
- Iterative TEA decryption core: inverse of the existing combinational TEA encrypt block.
- Computes one round per clock (two with the optional feature); registered valid/ready handshake on both sides.
- Sits on the receive side of the OFB/TEA datapath. It recovers plaintext from 64-bit blocks produced by the encrypt core under the same 128-bit key.

Parameters:
- ROUNDS, 32, number of rounds; legal range 1..63; must be even when TEA_DEC_UNROLL2_EN is defined.
- DELTA, 32'h9E3779B9, key-schedule constant; must equal the encrypt core's constant.

Ports:
- Interface rule: one clock; reset is asynchronous and active-high.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in/key valid.
- in_ready  output  1  core can accept a block (high only in IDLE).
- data_in  input  64  ciphertext; [63:32]=v0, [31:0]=v1.
- key  input  128  k0=[127:96], k1=[95:64], k2=[63:32], k3=[31:0].
- out_valid  output  1  data_out holds a finished plaintext.
- out_ready  input  1  downstream accepts data_out.
- data_out  output  64  plaintext {v0,v1}.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, any state, including mid-operation): state=IDLE, out_valid=0, busy=0, data_out=0, in_ready=1 once rst deasserts. Working registers v0/v1/sum/key/count clear to 0. Any in-flight block is discarded.
- All arithmetic is 32-bit modulo 2^32. Shifts are logical.
- Operator grouping must invert the encrypt core exactly. The encrypt round is:
  - v0' = (v0 + ((v1<<4)+k0)) ^ (v1+sum) ^ ((v1>>5)+k1)
  - v1' = (v1 + ((v0'<<4)+k2)) ^ (v0'+sum) ^ ((v0'>>5)+k3)
  - sum runs DELTA, 2*DELTA, ..., ROUNDS*DELTA.
- The decrypt round, using current sum, is applied in this order:
  1. v1 = (v1 ^ (v0+sum) ^ ((v0>>5)+k3)) - ((v0<<4)+k2)
  2. v0 = (v0 ^ (v1+sum) ^ ((v1>>5)+k1)) - ((v1<<4)+k0), using the new v1
  3. sum = sum - DELTA
- State IDLE:
  - in_ready=1.
  - On in_valid at a clock edge: capture data_in into v0/v1 and key into internal key registers.
  - Load sum = (DELTA*ROUNDS) mod 2^32 (32'hC6EF3720 for defaults) and count=ROUNDS, then go to RUN.
- State RUN:
  - in_ready=0, busy=1.
  - Each edge performs one round and decrements count.
  - On the edge that completes the last round (count==1): go to DONE and set out_valid=1.
- State DONE:
  - out_valid=1; data_out={v0,v1}, stable until accepted.
  - On out_ready at an edge: out_valid=0, go to IDLE.
  - No new block is accepted in the same cycle (in_ready=0 in DONE).
- Latency: block accepted at edge N → out_valid high after edge N+ROUNDS.
- Throughput: one block per ROUNDS+2 cycles with out_ready tied high.
- Key and data_in changes after acceptance have no effect on the running block.
- in_valid outside IDLE is ignored (not queued).
- out_ready while out_valid=0 is ignored.
- data_out outside DONE holds the last value (0 after reset); it is only meaningful with out_valid.

Optional Feature:
- Macro: TEA_DEC_UNROLL2_EN.
- Defined:
  - Two chained decrypt rounds per clock (sum and sum-DELTA); count decrements by 2.
  - Latency ROUNDS/2 cycles, throughput one block per ROUNDS/2+2 cycles.
  - Results identical to the 1-round build.
- Undefined: one round per clock as above.

Test Plan:
1. Reset values: assert rst with random inputs → out_valid=0, busy=0, data_out=64'h0. After release, in_ready=1.
2. Zero vector: key=0, pt=0 → encrypt with TEA core → ct; present ct with in_valid one cycle → out_valid exactly 32 cycles after acceptance edge; data_out=64'h0.
3. Nonzero round trip:
   - Stimulus: key=128'h0123456789ABCDEF_FEDCBA9876543210, pt=64'hDEADBEEF_CAFEBABE, encrypted via TEA core.
   - Required: data_out=64'hDEADBEEF_CAFEBABE.
   - Repeat for 1000 random key/pt pairs, all matching.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → out_valid, data_out stable; in_ready=0; in_valid pulses ignored. Then one out_ready cycle → IDLE; next accepted block decrypts correctly.
5. Reset mid-operation: assert rst after 15 rounds → out_valid=0, data_out=0 immediately (async). After release, a fresh block gives correct plaintext with full 32-cycle latency.
6. Input isolation: change key and data_in every cycle after acceptance → result still equals original plaintext. With TEA_DEC_UNROLL2_EN defined, the same vectors give the same results with 16-cycle latency.

Source files
------------

// File: rtl/tea_decrypt_iter.sv
// Iterative TEA decryption core: one round per clock, valid/ready handshake on both sides.
// Define TEA_DEC_UNROLL2_EN to chain two rounds per clock (ROUNDS must then be even).
module tea_decrypt_iter #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

`ifdef TEA_DEC_UNROLL2_EN
  localparam int unsigned Step = 2;
`else
  localparam int unsigned Step = 1;
`endif
  localparam logic [31:0] SumInit   = DELTA * 32'(ROUNDS);
  localparam logic [5:0]  CountInit = 6'(ROUNDS);
  localparam logic [5:0]  CountStep = 6'(Step);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e        state_q, state_d;
  logic [63:0]   v_q, v_d;
  logic [31:0]   sum_q, sum_d;
  logic [127:0]  key_q, key_d;
  logic [5:0]    count_q, count_d;
  logic [63:0]   dout_q, dout_d;
  logic          out_valid_q, out_valid_d;
  logic [63:0]   round_v;
  logic [31:0]   round_sum;

  // Undoes one encrypt round: v1 first, then v0 using the recovered v1.
  function automatic logic [63:0] dec_round(input logic [63:0] v, input logic [31:0] sum,
                                            input logic [127:0] k);
    logic [31:0] v0, v1;
    v0 = v[63:32];
    v1 = v[31:0];
    v1 = (v1 ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0])) - ((v0 << 4) + k[63:32]);
    v0 = (v0 ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64])) - ((v1 << 4) + k[127:96]);
    return {v0, v1};
  endfunction

  always_comb begin
    round_v   = dec_round(v_q, sum_q, key_q);
    round_sum = sum_q - DELTA;
`ifdef TEA_DEC_UNROLL2_EN
    round_v   = dec_round(round_v, round_sum, key_q);
    round_sum = round_sum - DELTA;
`endif
  end

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    sum_d       = sum_q;
    key_d       = key_q;
    count_d     = count_q;
    dout_d      = dout_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          v_d     = data_in;
          key_d   = key;
          sum_d   = SumInit;
          count_d = CountInit;
          state_d = StRun;
        end
      end
      StRun: begin
        v_d     = round_v;
        sum_d   = round_sum;
        count_d = count_q - CountStep;
        if (count_q == CountStep) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          dout_d      = round_v;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      v_q         <= '0;
      sum_q       <= '0;
      key_q       <= '0;
      count_q     <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      sum_q       <= sum_d;
      key_q       <= key_d;
      count_q     <= count_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign out_valid = out_valid_q;
  assign data_out  = dout_q;

endmodule

// File: tb/tb_tea_decrypt_iter.sv
// Self-checking bench for tea_decrypt_iter: plaintext is encrypted by a bench TEA model,
// fed to the core as ciphertext, and the recovered plaintext and timing are checked.
module tb_tea_decrypt_iter;
  localparam int unsigned Rounds = 32;
  localparam logic [31:0] Delta  = 32'h9E3779B9;
`ifdef TEA_DEC_UNROLL2_EN
  localparam int Lat = Rounds / 2;
`else
  localparam int Lat = Rounds;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  data_in;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [63:0]  data_out;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tea_decrypt_iter #(
    .ROUNDS(Rounds),
    .DELTA (Delta)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_in  (data_in),
    .key      (key),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out (data_out),
    .busy     (busy)
  );

  function automatic logic [63:0] tea_enc(input logic [63:0] pt, input logic [127:0] k,
                                          input int n);
    logic [31:0] v0, v1, sum;
    v0  = pt[63:32];
    v1  = pt[31:0];
    sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      sum = sum + Delta;
      v0 = (v0 + ((v1 << 4) + k[127:96])) ^ (v1 + sum) ^ ((v1 >> 5) + k[95:64]);
      v1 = (v1 + ((v0 << 4) + k[63:32])) ^ (v0 + sum) ^ ((v0 >> 5) + k[31:0]);
    end
    return {v0, v1};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a block in flight finishes Lat cycles after acceptance, then waits.
  logic        m_busy = 1'b0;
  logic        m_ov   = 1'b0;
  int          m_left = 0;
  logic [63:0] m_pt   = '0;
  logic [63:0] m_data = '0;
  logic [63:0] cur_pt = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_ov   = 1'b0;
      m_left = 0;
      m_data = '0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_left = Lat;
        m_pt   = cur_pt;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ov   = 1'b1;
        m_data = m_pt;
      end
    end else if (out_ready) begin
      m_ov   = 1'b0;
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("out_valid", out_valid, m_ov);
    check("busy", busy, m_busy);
    check("in_ready", in_ready, !m_busy);
    check("data_out", data_out, m_data);
  end

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_block(input logic [63:0] pt, input logic [127:0] k, input int hold,
                           input bit scramble);
    logic [63:0] ct;
    int          n;
    int          lat;
    logic [63:0] got;
    ct = tea_enc(pt, k, Rounds);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", in_ready, 1'b1);
    in_valid  = 1'b1;
    data_in   = ct;
    key       = k;
    cur_pt    = pt;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < Lat + 10) begin
      if (scramble) begin
        data_in  = {$urandom, $urandom};
        key      = rand_key();
        in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, Lat);
    got = data_out;
    check("plaintext", got, pt);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = {$urandom, $urandom};
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", data_out, pt);
      check("hold_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_to_idle", in_ready, 1'b1);
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    data_in   = '0;
    key       = '0;

    // Hand-computed single-round encryptions pin the bench's TEA model.
    check("model_zero_1r", tea_enc(64'h0, 128'h0, 1), 64'h9E3779B9_DBE8D32F);
    check("model_k0_1r", tea_enc(64'h0, {32'h1, 96'h0}, 1), 64'h9E3779B8_DBE8D33C);

    // Reset with noisy inputs.
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      data_in   = {$urandom, $urandom};
      key       = rand_key();
      @(posedge clk); #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_data_out", data_out, 64'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    run_block(64'h0, 128'h0, 0, 1'b0);
    run_block(64'hDEADBEEF_CAFEBABE, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 1'b0);
    run_block(64'h01234567_89ABCDEF, rand_key(), 10, 1'b1);
    run_block({$urandom, $urandom}, rand_key(), 0, 1'b0);

    // Reset in the middle of a block.
    in_valid = 1'b1;
    data_in  = tea_enc(64'h55AA55AA_12345678, 128'h1, Rounds);
    key      = 128'h1;
    cur_pt   = 64'h55AA55AA_12345678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
    end
    check("midop_busy_before", busy, 1'b1);
    rst = 1'b1;
    #1;
    check("midop_out_valid", out_valid, 1'b0);
    check("midop_data_out", data_out, 64'h0);
    check("midop_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_block(64'hFEEDFACE_0BADF00D, 128'h0123456789ABCDEF_FEDCBA9876543210, 0, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      run_block({$urandom, $urandom}, rand_key(), int'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
